// File: rtl/i2c_arb_pkg.sv
// Shared encodings and field widths for the i2c_master command arbiter.
`default_nettype none

package i2c_arb_pkg;

  localparam int I2C_SADDR_W   = 7;
  localparam int I2C_REGADDR_W = 16;
  localparam int I2C_LEN_W     = 16;
  localparam int I2C_DATA_W    = 8;
  localparam int GRANT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_BUSY    = 2'b10,
    ST_RELEASE = 2'b11
  } arb_state_e;

  typedef struct packed {
    logic [I2C_SADDR_W-1:0]   saddr;
    logic                     read_write;
    logic                     addr_length;
    logic [I2C_REGADDR_W-1:0] start_addr;
    logic [I2C_LEN_W-1:0]     data_length;
  } i2c_cmd_t;

endpackage

`default_nettype wire

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_grant, wrapping.
`default_nettype none

module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] grant,
  output logic               any
);

  logic [GRANT_W-1:0] lo_idx;
  logic [GRANT_W-1:0] hi_idx;
  logic               hi_any;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = GRANT_W'(i);
        if (GRANT_W'(i) > last_grant) begin
          hi_idx = GRANT_W'(i);
          hi_any = 1'b1;
        end
      end
    end
    any   = |req;
    grant = hi_any ? hi_idx : lo_idx;
  end

endmodule

`default_nettype wire

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one i2c_master command/data port among NUM_REQ requesters.
`default_nettype none

module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [NUM_REQ-1:0]                 req_cmd_valid,
  output logic [NUM_REQ-1:0]                 req_cmd_ready,
  output logic [NUM_REQ-1:0]                 req_cmd_done,
  output logic [NUM_REQ-1:0]                 req_cmd_error,
  output logic [NUM_REQ-1:0]                 req_cmd_rollback,
  input  logic [I2C_SADDR_W*NUM_REQ-1:0]     req_i2c_slave_addr,
  input  logic [NUM_REQ-1:0]                 req_i2c_read_write,
  input  logic [NUM_REQ-1:0]                 req_i2c_addr_length,
  input  logic [I2C_REGADDR_W*NUM_REQ-1:0]   req_i2c_start_addr,
  input  logic [I2C_LEN_W*NUM_REQ-1:0]       req_i2c_data_length,
  output logic [NUM_REQ-1:0]                 req_wr_data_ready,
  input  logic [I2C_DATA_W*NUM_REQ-1:0]      req_wr_data,
  output logic [NUM_REQ-1:0]                 req_rd_data_valid,
  output logic [I2C_DATA_W-1:0]              req_rd_data,
  output logic                               m_cmd_valid,
  input  logic                               m_cmd_ready,
  input  logic                               m_cmd_done,
  input  logic                               m_cmd_error,
  input  logic                               m_cmd_rollback,
  output logic [I2C_SADDR_W-1:0]             m_i2c_slave_addr,
  output logic                               m_i2c_read_write,
  output logic                               m_i2c_addr_length,
  output logic [I2C_REGADDR_W-1:0]           m_i2c_start_addr,
  output logic [I2C_LEN_W-1:0]               m_i2c_data_length,
  input  logic                               m_wr_data_ready,
  output logic [I2C_DATA_W-1:0]              m_wr_data,
  input  logic                               m_rd_data_valid,
  input  logic [I2C_DATA_W-1:0]              m_rd_data,
  output logic [GRANT_W-1:0]                 grant_id,
  output logic                               busy,
  output logic                               timeout_flag
);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  i2c_cmd_t           cmd_q, cmd_d;
  logic [31:0]        wdog_q, wdog_d;
  logic               timeout_q, timeout_d;

  logic [GRANT_W-1:0]    pick_idx;
  logic                  pick_any;
  logic [NUM_REQ-1:0]    grant_oh;
  i2c_cmd_t              live_cmd;
  i2c_cmd_t              out_cmd;
  logic                  live_valid;
  logic [I2C_DATA_W-1:0] live_wr_data;
  logic                  in_issue;
  logic                  in_busy;

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (req_cmd_valid),
    .last_grant (last_grant_q),
    .grant      (pick_idx),
    .any        (pick_any)
  );

  // Select the granted requester's command fields, valid and write byte.
  always_comb begin
    grant_oh     = '0;
    live_cmd     = '0;
    live_valid   = 1'b0;
    live_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        grant_oh[i]          = 1'b1;
        live_valid           = req_cmd_valid[i];
        live_cmd.saddr       = req_i2c_slave_addr[I2C_SADDR_W*i +: I2C_SADDR_W];
        live_cmd.read_write  = req_i2c_read_write[i];
        live_cmd.addr_length = req_i2c_addr_length[i];
        live_cmd.start_addr  = req_i2c_start_addr[I2C_REGADDR_W*i +: I2C_REGADDR_W];
        live_cmd.data_length = req_i2c_data_length[I2C_LEN_W*i +: I2C_LEN_W];
        live_wr_data         = req_wr_data[I2C_DATA_W*i +: I2C_DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    wdog_d       = wdog_q;
    timeout_d    = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A withdrawn request forfeits the slot without advancing the rotation.
        if (!live_valid) begin
          state_d = ST_IDLE;
        end else if (m_cmd_ready) begin
          cmd_d   = live_cmd;
          wdog_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (m_cmd_done) begin
          timeout_d = 1'b0;
          state_d   = ST_RELEASE;
        end else if ((TIMEOUT_CYCLES != 0) && !timeout_q) begin
          wdog_d = wdog_q + 32'd1;
          if (wdog_d == TIMEOUT_CYCLES) begin
            timeout_d = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
      cmd_q        <= '0;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
    end
  end

  assign in_issue = (state_q == ST_ISSUE);
  assign in_busy  = (state_q == ST_BUSY);

  // Fields track the requester live while issuing, then freeze for the whole transfer.
  always_comb begin
    out_cmd = '0;
    if (in_issue) begin
      out_cmd = live_cmd;
    end else if (in_busy) begin
      out_cmd = cmd_q;
    end
  end

  assign m_cmd_valid       = in_issue && live_valid;
  assign m_i2c_slave_addr  = out_cmd.saddr;
  assign m_i2c_read_write  = out_cmd.read_write;
  assign m_i2c_addr_length = out_cmd.addr_length;
  assign m_i2c_start_addr  = out_cmd.start_addr;
  assign m_i2c_data_length = out_cmd.data_length;

  assign req_cmd_ready     = {NUM_REQ{in_issue && m_cmd_ready}} & grant_oh;
  assign req_cmd_done      = {NUM_REQ{in_busy && m_cmd_done}} & grant_oh;
  assign req_cmd_error     = {NUM_REQ{in_busy && m_cmd_error}} & grant_oh;
  assign req_cmd_rollback  = {NUM_REQ{in_busy && m_cmd_rollback}} & grant_oh;
  assign req_wr_data_ready = {NUM_REQ{in_busy && m_wr_data_ready}} & grant_oh;
  assign req_rd_data_valid = {NUM_REQ{in_busy && m_rd_data_valid}} & grant_oh;
  assign req_rd_data       = in_busy ? m_rd_data : '0;
  assign m_wr_data         = in_busy ? live_wr_data : '0;

  assign grant_id     = grant_q;
  assign busy         = in_issue || in_busy;
  assign timeout_flag = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed scoreboard bench for i2c_cmd_arbiter (4 requesters, 100-cycle watchdog).
`default_nettype none

module tb_i2c_cmd_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req_cmd_valid;
  logic [N-1:0]  req_cmd_ready, req_cmd_done, req_cmd_error, req_cmd_rollback;
  logic [7*N-1:0]  req_i2c_slave_addr;
  logic [N-1:0]  req_i2c_read_write, req_i2c_addr_length;
  logic [16*N-1:0] req_i2c_start_addr, req_i2c_data_length;
  logic [N-1:0]  req_wr_data_ready, req_rd_data_valid;
  logic [8*N-1:0]  req_wr_data;
  logic [7:0]    req_rd_data;
  logic          m_cmd_valid, m_cmd_ready, m_cmd_done, m_cmd_error, m_cmd_rollback;
  logic [6:0]    m_i2c_slave_addr;
  logic          m_i2c_read_write, m_i2c_addr_length;
  logic [15:0]   m_i2c_start_addr, m_i2c_data_length;
  logic          m_wr_data_ready, m_rd_data_valid;
  logic [7:0]    m_wr_data, m_rd_data;
  logic [2:0]    grant_id;
  logic          busy, timeout_flag;

  typedef struct {
    int          g;
    logic [6:0]  sa;
    logic        rw;
    logic        al;
    logic [15:0] st;
    logic [15:0] ln;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  i2c_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rstn(rstn),
    .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
    .req_cmd_done(req_cmd_done), .req_cmd_error(req_cmd_error),
    .req_cmd_rollback(req_cmd_rollback),
    .req_i2c_slave_addr(req_i2c_slave_addr), .req_i2c_read_write(req_i2c_read_write),
    .req_i2c_addr_length(req_i2c_addr_length), .req_i2c_start_addr(req_i2c_start_addr),
    .req_i2c_data_length(req_i2c_data_length),
    .req_wr_data_ready(req_wr_data_ready), .req_wr_data(req_wr_data),
    .req_rd_data_valid(req_rd_data_valid), .req_rd_data(req_rd_data),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_done(m_cmd_done), .m_cmd_error(m_cmd_error), .m_cmd_rollback(m_cmd_rollback),
    .m_i2c_slave_addr(m_i2c_slave_addr), .m_i2c_read_write(m_i2c_read_write),
    .m_i2c_addr_length(m_i2c_addr_length), .m_i2c_start_addr(m_i2c_start_addr),
    .m_i2c_data_length(m_i2c_data_length),
    .m_wr_data_ready(m_wr_data_ready), .m_wr_data(m_wr_data),
    .m_rd_data_valid(m_rd_data_valid), .m_rd_data(m_rd_data),
    .grant_id(grant_id), .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int i, input logic [6:0] sa, input logic rw, input logic al,
                           input logic [15:0] st, input logic [15:0] ln, input bit push);
    exp_t e;
    req_i2c_slave_addr[7*i +: 7]   = sa;
    req_i2c_read_write[i]          = rw;
    req_i2c_addr_length[i]         = al;
    req_i2c_start_addr[16*i +: 16] = st;
    req_i2c_data_length[16*i +: 16] = ln;
    req_cmd_valid[i]               = 1'b1;
    if (push) begin
      e.g = i; e.sa = sa; e.rw = rw; e.al = al; e.st = st; e.ln = ln;
      exp_q.push_back(e);
    end
  endtask

  // Waits (bounded) for a command on the master port and checks it against the scoreboard.
  task automatic expect_issue(output int waited, output int g);
    exp_t e;
    waited = 0;
    g = 0;
    while (m_cmd_valid !== 1'b1 && waited < 16) begin
      tick();
      waited++;
    end
    chk("issue_seen", 32'(m_cmd_valid), 32'd1);
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    g = e.g;
    chk("grant_id", 32'(grant_id), 32'(e.g));
    chk("busy_issue", 32'(busy), 32'd1);
    chk("cmd_ready_onehot", 32'(req_cmd_ready), 32'd1 << e.g);
    chk("saddr", 32'(m_i2c_slave_addr), 32'(e.sa));
    chk("read_write", 32'(m_i2c_read_write), 32'(e.rw));
    chk("addr_length", 32'(m_i2c_addr_length), 32'(e.al));
    chk("start_addr", 32'(m_i2c_start_addr), 32'(e.st));
    chk("data_length", 32'(m_i2c_data_length), 32'(e.ln));
  endtask

  task automatic accept(input int g);
    tick();
    req_cmd_valid[g] = 1'b0;
    #1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("no_valid_in_busy", 32'(m_cmd_valid), 32'd0);
    chk("no_ready_in_busy", 32'(req_cmd_ready), 32'd0);
  endtask

  task automatic finish_cmd(input int g);
    m_cmd_done = 1'b1;
    #1;
    chk("done_route", 32'(req_cmd_done), 32'd1 << g);
    tick();
    m_cmd_done = 1'b0;
    #1;
    chk("busy_release", 32'(busy), 32'd0);
    chk("no_valid_release", 32'(m_cmd_valid), 32'd0);
    tick();
  endtask

  initial begin
    int w, g;
    exp_t e;
    rstn = 1'b0;
    req_cmd_valid = '0; req_i2c_slave_addr = '0; req_i2c_read_write = '0;
    req_i2c_addr_length = '0; req_i2c_start_addr = '0; req_i2c_data_length = '0;
    req_wr_data = '0; m_cmd_ready = 1'b1; m_cmd_done = 1'b0; m_cmd_error = 1'b0;
    m_cmd_rollback = 1'b0; m_wr_data_ready = 1'b0; m_rd_data_valid = 1'b0; m_rd_data = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_valid", 32'(m_cmd_valid), 32'd0);
    chk("rst_timeout", 32'(timeout_flag), 32'd0);
    rstn = 1'b1;
    tick();

    // All four requesting continuously: rotation 0,1,2,3,0 with a two-cycle gap.
    for (int i = 0; i < N; i++)
      drive_req(i, 7'(8'h20 + i), i[0], i[1], 16'(32'h100 * (i + 1)), 16'(i + 1), 1'b1);
    e = exp_q[0];
    exp_q.push_back(e);
    for (int k = 0; k < 5; k++) begin
      expect_issue(w, g);
      if (k > 0) chk("rr_gap", 32'(w), 32'd1);
      accept(g);
      req_cmd_valid[g] = 1'b1;
      finish_cmd(g);
    end
    req_cmd_valid = '0;
    tick();

    // Single read from requester 1.
    drive_req(1, 7'h50, 1'b1, 1'b0, 16'h0010, 16'd4, 1'b1);
    tick();
    chk("latency_one", 32'(m_cmd_valid), 32'd1);
    expect_issue(w, g);
    accept(g);
    for (int k = 0; k < 4; k++) begin
      m_rd_data_valid = 1'b1;
      m_rd_data = 8'(8'hA0 + k);
      #1;
      chk("rd_valid_route", 32'(req_rd_data_valid), 32'h2);
      chk("rd_data", 32'(req_rd_data), 32'(8'hA0 + k));
      tick();
      m_rd_data_valid = 1'b0;
      tick();
    end
    finish_cmd(1);

    // Requester 2 owns; error and rollback are routed, requester 0 waits for release.
    drive_req(2, 7'h33, 1'b0, 1'b1, 16'h0400, 16'd2, 1'b1);
    expect_issue(w, g);
    chk("grant_after_1", 32'(g), 32'd2);
    accept(g);
    drive_req(0, 7'h11, 1'b0, 1'b0, 16'h0010, 16'd3, 1'b1);
    #1;
    chk("waiting_no_ready", 32'(req_cmd_ready), 32'd0);
    m_cmd_error = 1'b1;
    #1;
    chk("err_route", 32'(req_cmd_error), 32'h4);
    chk("err_no_done", 32'(req_cmd_done), 32'd0);
    chk("err_no_rb", 32'(req_cmd_rollback), 32'd0);
    tick();
    m_cmd_error = 1'b0;
    m_cmd_rollback = 1'b1;
    #1;
    chk("rb_route", 32'(req_cmd_rollback), 32'h4);
    chk("busy_after_err", 32'(busy), 32'd1);
    tick();
    m_cmd_rollback = 1'b0;
    finish_cmd(2);
    chk("idle_no_valid", 32'(m_cmd_valid), 32'd0);

    // Requester 0 changes its address after accept; master sees the latched value.
    expect_issue(w, g);
    chk("gap_after_release", 32'(w), 32'd1);
    accept(g);
    req_i2c_start_addr[15:0] = 16'h1234;
    req_wr_data[7:0] = 8'h5A;
    req_wr_data[23:16] = 8'hEE;
    m_wr_data_ready = 1'b1;
    #1;
    chk("start_held", 32'(m_i2c_start_addr), 32'h0010);
    chk("wr_ready_route", 32'(req_wr_data_ready), 32'h1);
    chk("wr_data_mux", 32'(m_wr_data), 32'h5A);
    tick();
    m_wr_data_ready = 1'b0;
    chk("start_held_2", 32'(m_i2c_start_addr), 32'h0010);
    finish_cmd(0);

    // Status pulses while idle are dropped.
    m_cmd_done = 1'b1;
    m_cmd_error = 1'b1;
    #1;
    chk("idle_done_drop", 32'(req_cmd_done), 32'd0);
    chk("idle_err_drop", 32'(req_cmd_error), 32'd0);
    tick();
    m_cmd_done = 1'b0;
    m_cmd_error = 1'b0;

    // Watchdog: flag after 100 BUSY cycles, cleared by a late done.
    drive_req(3, 7'h68, 1'b1, 1'b1, 16'hBEEF, 16'd16, 1'b1);
    expect_issue(w, g);
    accept(g);
    repeat (99) tick();
    chk("timeout_before", 32'(timeout_flag), 32'd0);
    tick();
    chk("timeout_set", 32'(timeout_flag), 32'd1);
    chk("timeout_owner_kept", 32'(busy), 32'd1);
    chk("timeout_grant", 32'(grant_id), 32'd3);
    finish_cmd(3);
    chk("timeout_cleared", 32'(timeout_flag), 32'd0);

    // Asynchronous reset in the middle of a transfer.
    drive_req(1, 7'h44, 1'b0, 1'b0, 16'h0022, 16'd1, 1'b1);
    expect_issue(w, g);
    accept(g);
    #2;
    rstn = 1'b0;
    m_cmd_done = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_grant", 32'(grant_id), 32'd0);
    chk("arst_saddr", 32'(m_i2c_slave_addr), 32'd0);
    chk("arst_no_done", 32'(req_cmd_done), 32'd0);
    m_cmd_done = 1'b0;
    tick();
    rstn = 1'b1;
    drive_req(0, 7'h01, 1'b0, 1'b0, 16'h0001, 16'd1, 1'b1);
    drive_req(2, 7'h02, 1'b1, 1'b0, 16'h0002, 16'd2, 1'b1);
    expect_issue(w, g);
    chk("post_reset_first", 32'(g), 32'd0);
    accept(g);
    finish_cmd(0);
    expect_issue(w, g);
    accept(g);
    finish_cmd(2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
